// File: rtl/opcodes.sv
// Shared RV32I decode definitions: instruction/register types, casez match
// patterns, immediate extraction and the ALU-class classifier.
package opcodes;

    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;

    typedef logic [31:0]         instruction_t;
    typedef logic [XLEN_DEF-1:0] register_t;
    typedef logic [4:0]          reg_idx_t;

    typedef enum logic [2:0] {
        CLS_NONE,
        CLS_R,
        CLS_I,
        CLS_SH,
        CLS_LUI,
        CLS_AUIPC
    } op_class_t;

    // Field order: funct7 | rs2 | rs1 | funct3 | rd | opcode
    localparam instruction_t M_ADD   = 32'b0000000_?????_?????_000_?????_0110011;
    localparam instruction_t M_SUB   = 32'b0100000_?????_?????_000_?????_0110011;
    localparam instruction_t M_SLL   = 32'b0000000_?????_?????_001_?????_0110011;
    localparam instruction_t M_SLT   = 32'b0000000_?????_?????_010_?????_0110011;
    localparam instruction_t M_SLTU  = 32'b0000000_?????_?????_011_?????_0110011;
    localparam instruction_t M_XOR   = 32'b0000000_?????_?????_100_?????_0110011;
    localparam instruction_t M_SRL   = 32'b0000000_?????_?????_101_?????_0110011;
    localparam instruction_t M_SRA   = 32'b0100000_?????_?????_101_?????_0110011;
    localparam instruction_t M_OR    = 32'b0000000_?????_?????_110_?????_0110011;
    localparam instruction_t M_AND   = 32'b0000000_?????_?????_111_?????_0110011;
    localparam instruction_t M_ADDI  = 32'b???????_?????_?????_000_?????_0010011;
    localparam instruction_t M_SLTI  = 32'b???????_?????_?????_010_?????_0010011;
    localparam instruction_t M_SLTIU = 32'b???????_?????_?????_011_?????_0010011;
    localparam instruction_t M_XORI  = 32'b???????_?????_?????_100_?????_0010011;
    localparam instruction_t M_ORI   = 32'b???????_?????_?????_110_?????_0010011;
    localparam instruction_t M_ANDI  = 32'b???????_?????_?????_111_?????_0010011;
    localparam instruction_t M_SLLI  = 32'b0000000_?????_?????_001_?????_0010011;
    localparam instruction_t M_SRLI  = 32'b0000000_?????_?????_101_?????_0010011;
    localparam instruction_t M_SRAI  = 32'b0100000_?????_?????_101_?????_0010011;
    localparam instruction_t M_LUI   = 32'b???????_?????_?????_???_?????_0110111;
    localparam instruction_t M_AUIPC = 32'b???????_?????_?????_???_?????_0010111;

    function automatic reg_idx_t get_rs1(input instruction_t instr);
        return instr[19:15];
    endfunction

    function automatic reg_idx_t get_rs2(input instruction_t instr);
        return instr[24:20];
    endfunction

    function automatic reg_idx_t get_rd(input instruction_t instr);
        return instr[11:7];
    endfunction

    function automatic register_t imm_i(input instruction_t instr);
        return {{20{instr[31]}}, instr[31:20]};
    endfunction

    function automatic register_t imm_u(input instruction_t instr);
        return {instr[31:12], 12'b0};
    endfunction

    // Shift amounts are zero-extended; the funct7 bits above them are not data.
    function automatic register_t shamt(input instruction_t instr);
        return {27'b0, instr[24:20]};
    endfunction

    function automatic op_class_t classify(input instruction_t instr);
        op_class_t cls;
        cls = CLS_NONE;
        casez (instr)
            M_ADD, M_SUB, M_SLL, M_SLT, M_SLTU,
            M_XOR, M_SRL, M_SRA, M_OR, M_AND:       cls = CLS_R;
            M_SLLI, M_SRLI, M_SRAI:                 cls = CLS_SH;
            M_ADDI, M_SLTI, M_SLTIU,
            M_XORI, M_ORI, M_ANDI:                  cls = CLS_I;
            M_LUI:                                  cls = CLS_LUI;
            M_AUIPC:                                cls = CLS_AUIPC;
            default:                                cls = CLS_NONE;
        endcase
        return cls;
    endfunction

    function automatic logic is_alu_op(input instruction_t instr);
        return classify(instr) != CLS_NONE;
    endfunction

endpackage

// File: rtl/op_regfile.sv
// Integer register file: two asynchronous read ports, one write port,
// x0 reads as zero and ignores writes.
module op_regfile
    import opcodes::*;
#(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  reg_idx_t        raddr1,
    input  reg_idx_t        raddr2,
    output logic [XLEN-1:0] rdata1,
    output logic [XLEN-1:0] rdata2,
    input  logic            we,
    input  reg_idx_t        waddr,
    input  logic [XLEN-1:0] wdata
);

    logic [XLEN-1:0] regs [NREGS];

    // NOTE: the array is reset explicitly so a reset also clears architectural
    // state; this costs a reset net per flop instead of allowing a RAM macro.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we && waddr != '0) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata1 = (raddr1 == '0) ? '0 : regs[raddr1];
    assign rdata2 = (raddr2 == '0) ? '0 : regs[raddr2];

endmodule

// File: rtl/operand_fetch.sv
// RV32I operand fetch / issue stage with a per-register pending scoreboard.
// Define OPFETCH_BYPASS_EN to let the writeback port resolve a dependency in
// the same cycle it retires (operand forwarded from wb_data).
module operand_fetch
    import opcodes::*;
#(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  instruction_t in_instr,
    input  register_t    in_pc,
    input  logic         wb_en,
    input  reg_idx_t     wb_rd,
    input  register_t    wb_data,
    output logic         alu_enable,
    output instruction_t alu_instr,
    output register_t    alu_op1,
    output register_t    alu_op2,
    output register_t    alu_pc,
    output reg_idx_t     alu_rd,
    output logic         illegal
);

    op_class_t        cls;
    logic             alu_op;
    logic             use_rs1;
    logic             use_rs2;
    reg_idx_t         rs1;
    reg_idx_t         rs2;
    reg_idx_t         rd;
    logic             hazard;
    logic             accept;
    logic             issue;
    logic [NREGS-1:0] pending;
    logic [NREGS-1:0] pending_nxt;
    logic [NREGS-1:0] set_mask;
    logic [NREGS-1:0] clr_mask;
    logic [NREGS-1:0] busy;
    register_t        rdata1;
    register_t        rdata2;
    register_t        src1;
    register_t        src2;
    register_t        op1_nxt;
    register_t        op2_nxt;

    op_regfile #(
        .XLEN  (XLEN),
        .NREGS (NREGS)
    ) u_regfile (
        .clk    (clk),
        .rst    (rst),
        .raddr1 (rs1),
        .raddr2 (rs2),
        .rdata1 (rdata1),
        .rdata2 (rdata2),
        .we     (wb_en),
        .waddr  (wb_rd),
        .wdata  (wb_data)
    );

    always_comb begin
        cls     = classify(in_instr);
        alu_op  = is_alu_op(in_instr);
        rs1     = get_rs1(in_instr);
        rs2     = get_rs2(in_instr);
        rd      = get_rd(in_instr);
        use_rs1 = (cls == CLS_R) || (cls == CLS_I) || (cls == CLS_SH);
        use_rs2 = (cls == CLS_R);
    end

    always_comb begin
        clr_mask = '0;
        if (wb_en && wb_rd != '0) begin
            clr_mask[wb_rd] = 1'b1;
        end
    end

`ifdef OPFETCH_BYPASS_EN
    // A register retiring this cycle is no longer a hazard; its value is forwarded.
    assign busy = pending & ~clr_mask;
    assign src1 = (wb_en && wb_rd == rs1 && rs1 != '0) ? wb_data : rdata1;
    assign src2 = (wb_en && wb_rd == rs2 && rs2 != '0) ? wb_data : rdata2;
`else
    assign busy = pending;
    assign src1 = rdata1;
    assign src2 = rdata2;
`endif

    always_comb begin
        hazard = alu_op && ((use_rs1 && busy[rs1]) ||
                            (use_rs2 && busy[rs2]) ||
                            busy[rd]);
        in_ready = rst && !hazard;
        accept   = in_valid && in_ready;
        issue    = accept && alu_op;

        set_mask = '0;
        if (issue && rd != '0) begin
            set_mask[rd] = 1'b1;
        end
        // Set is applied after clear so a same-cycle issue keeps the bit pending.
        pending_nxt = (pending & ~clr_mask) | set_mask;
    end

    always_comb begin
        op1_nxt = '0;
        op2_nxt = '0;
        case (cls)
            CLS_R: begin
                op1_nxt = src1;
                op2_nxt = src2;
            end
            CLS_I: begin
                op1_nxt = src1;
                op2_nxt = imm_i(in_instr);
            end
            CLS_SH: begin
                op1_nxt = src1;
                op2_nxt = shamt(in_instr);
            end
            CLS_LUI, CLS_AUIPC: begin
                op1_nxt = imm_u(in_instr);
                op2_nxt = '0;
            end
            default: begin
                op1_nxt = '0;
                op2_nxt = '0;
            end
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values computed by the combinational blocks above.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending    <= '0;
            alu_enable <= 1'b0;
            illegal    <= 1'b0;
            alu_instr  <= '0;
            alu_op1    <= '0;
            alu_op2    <= '0;
            alu_pc     <= '0;
            alu_rd     <= '0;
        end else begin
            pending    <= pending_nxt;
            alu_enable <= issue;
            illegal    <= accept && !alu_op;
            if (issue) begin
                alu_instr <= in_instr;
                alu_op1   <= op1_nxt;
                alu_op2   <= op2_nxt;
                alu_pc    <= in_pc;
                alu_rd    <= rd;
            end
        end
    end

endmodule

// File: tb/tb_operand_fetch.sv
// Directed self-checking bench for operand_fetch; expectations follow
// OPFETCH_BYPASS_EN the same way the design is built.
module tb_operand_fetch;
    import opcodes::*;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    instruction_t in_instr;
    register_t    in_pc;
    logic         wb_en;
    reg_idx_t     wb_rd;
    register_t    wb_data;
    logic         alu_enable;
    instruction_t alu_instr;
    register_t    alu_op1;
    register_t    alu_op2;
    register_t    alu_pc;
    reg_idx_t     alu_rd;
    logic         illegal;

    int checks = 0;
    int errors = 0;

    operand_fetch dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_instr   (in_instr),
        .in_pc      (in_pc),
        .wb_en      (wb_en),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .alu_enable (alu_enable),
        .alu_instr  (alu_instr),
        .alu_op1    (alu_op1),
        .alu_op2    (alu_op2),
        .alu_pc     (alu_pc),
        .alu_rd     (alu_rd),
        .illegal    (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic instruction_t enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                           input logic [2:0] f3, input logic [4:0] rd,
                                           input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic instruction_t enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                           input logic [4:0] rs1, input logic [2:0] f3,
                                           input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic instruction_t enc_u(input logic [19:0] imm, input logic [4:0] rd,
                                           input logic [6:0] op);
        return {imm, rd, op};
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic present(input instruction_t instr, input register_t pc);
        in_valid = 1'b1;
        in_instr = instr;
        in_pc    = pc;
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        #1;
    endtask

    task automatic retire(input reg_idx_t r, input register_t d);
        wb_en   = 1'b1;
        wb_rd   = r;
        wb_data = d;
        tick();
        wb_en = 1'b0;
        #1;
    endtask

    initial begin
        rst = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0;
        wb_en = 1'b0; wb_rd = '0; wb_data = '0;
        repeat (2) @(posedge clk);
        #2;
        check("rst_alu_enable", alu_enable, 0);
        check("rst_illegal", illegal, 0);
        check("rst_alu_op1", alu_op1, 0);
        check("rst_alu_rd", alu_rd, 0);
        check("rst_in_ready", in_ready, 0);
        rst = 1'b1;
        #1;
        check("ready_after_rst", in_ready, 1);

        // ADDI x1,x0,5
        present(enc_i(12'd5, 5'd0, 3'b000, 5'd1, 7'b0010011), 32'h0);
        check("addi_ready", in_ready, 1);
        tick();
        idle();
        check("addi_enable", alu_enable, 1);
        check("addi_op1", alu_op1, 32'h0);
        check("addi_op2", alu_op2, 32'h5);
        check("addi_rd", alu_rd, 1);

        // ADD x5,x1,x1 depends on pending x1
        present(enc_r(7'b0, 5'd1, 5'd1, 3'b000, 5'd5), 32'h4);
        check("raw_stall", in_ready, 0);
        tick();
        check("enable_one_cycle", alu_enable, 0);
        check("raw_still_stalled", in_ready, 0);
        wb_en = 1'b1; wb_rd = 5'd1; wb_data = 32'h11;
        #1;
`ifdef OPFETCH_BYPASS_EN
        check("raw_bypass_ready", in_ready, 1);
        tick();
        wb_en = 1'b0;
        idle();
`else
        check("raw_wb_cycle_stall", in_ready, 0);
        tick();
        wb_en = 1'b0;
        #1;
        check("raw_ready_after_wb", in_ready, 1);
        tick();
        idle();
`endif
        check("raw_enable", alu_enable, 1);
        check("raw_op1", alu_op1, 32'h11);
        check("raw_op2", alu_op2, 32'h11);
        check("raw_rd", alu_rd, 5);
        retire(5'd5, 32'h22);

        // ADDI x2,x0,-1 then SRAI x3,x2,4
        present(enc_i(12'hFFF, 5'd0, 3'b000, 5'd2, 7'b0010011), 32'h8);
        tick();
        idle();
        check("neg_imm_op2", alu_op2, 32'hFFFF_FFFF);
        retire(5'd2, 32'hFFFF_FFFF);
        present(enc_i(12'h404, 5'd2, 3'b101, 5'd3, 7'b0010011), 32'hC);
        check("srai_ready", in_ready, 1);
        tick();
        idle();
        check("srai_enable", alu_enable, 1);
        check("srai_op1", alu_op1, 32'hFFFF_FFFF);
        check("srai_shamt", alu_op2, 32'h4);

        // LUI x4 then AUIPC x7 back-to-back
        present(enc_u(20'h12345, 5'd4, 7'b0110111), 32'h10);
        tick();
        check("lui_op1", alu_op1, 32'h1234_5000);
        check("lui_op2", alu_op2, 32'h0);
        present(enc_u(20'h12345, 5'd7, 7'b0010111), 32'h100);
        check("b2b_ready", in_ready, 1);
        tick();
        idle();
        check("auipc_enable", alu_enable, 1);
        check("auipc_op1", alu_op1, 32'h1234_5000);
        check("auipc_pc", alu_pc, 32'h100);
        check("auipc_rd", alu_rd, 7);

        // ADDI x6 issued while a writeback to x6 strobes: set must win
        wb_en = 1'b1; wb_rd = 5'd6; wb_data = 32'h66;
        present(enc_i(12'd1, 5'd0, 3'b000, 5'd6, 7'b0010011), 32'h20);
        tick();
        wb_en = 1'b0;
        present(enc_i(12'd2, 5'd0, 3'b000, 5'd6, 7'b0010011), 32'h24);
        check("waw_set_wins", in_ready, 0);
        tick();
        check("waw_still_stalled", in_ready, 0);
        wb_en = 1'b1; wb_rd = 5'd6; wb_data = 32'h67;
        #1;
`ifdef OPFETCH_BYPASS_EN
        check("waw_bypass_ready", in_ready, 1);
        tick();
        wb_en = 1'b0;
        idle();
`else
        check("waw_wb_cycle_stall", in_ready, 0);
        tick();
        wb_en = 1'b0;
        #1;
        check("waw_ready_after_wb", in_ready, 1);
        tick();
        idle();
`endif
        check("waw_enable", alu_enable, 1);
        check("waw_op2", alu_op2, 32'h2);
        present(enc_i(12'd0, 5'd6, 3'b000, 5'd12, 7'b0010011), 32'h28);
        check("x6_still_pending", in_ready, 0);
        idle();

        // LW x8,0(x1) is not ALU class
        present(enc_i(12'd0, 5'd1, 3'b010, 5'd8, 7'b0000011), 32'h30);
        check("lw_ready", in_ready, 1);
        tick();
        idle();
        check("lw_illegal", illegal, 1);
        check("lw_no_enable", alu_enable, 0);
        tick();
        check("illegal_one_cycle", illegal, 0);
        present(enc_i(12'd0, 5'd8, 3'b000, 5'd9, 7'b0010011), 32'h34);
        check("lw_no_pending", in_ready, 1);
        idle();

        // Reset during a stall
        present(enc_i(12'd3, 5'd0, 3'b000, 5'd10, 7'b0010011), 32'h40);
        tick();
        present(enc_r(7'b0, 5'd10, 5'd10, 3'b000, 5'd11), 32'h44);
        check("pre_reset_stall", in_ready, 0);
        rst = 1'b0;
        #1;
        check("midrst_enable", alu_enable, 0);
        check("midrst_op1", alu_op1, 0);
        check("midrst_rd", alu_rd, 0);
        idle();
        tick();
        rst = 1'b1;
        #1;
        tick();
        check("no_issue_after_rst", alu_enable, 0);
        present(enc_r(7'b0, 5'd10, 5'd10, 3'b000, 5'd11), 32'h44);
        check("pending_discarded", in_ready, 1);
        tick();
        idle();
        check("post_rst_enable", alu_enable, 1);
        check("post_rst_regfile_clear", alu_op1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/operand_fetch.md
# operand_fetch

Issue stage directly upstream of the ALU. It accepts one decoded RV32I integer instruction per cycle over a valid/ready handshake and reads rs1/rs2 from an internal 32x32 register file. It builds the ALU operands (register, sign-extended immediate, shamt or upper immediate) and presents them to the ALU with a one-cycle `alu_enable` pulse. A per-register pending scoreboard stalls RAW/WAW hazards until the writeback port retires the older result.

## Interface
- `XLEN`, 32: operand/register width; must equal width of `register_t`
- `NREGS`, 32: architectural registers; x0 hardwired to zero
- `clk` in 1: single clock
- `rst` in 1: reset, asynchronous and active-low
- `in_valid` in 1: decoded instruction available
- `in_ready` out 1: stage can accept this cycle
- `in_instr` in `instruction_t`: raw 32-bit instruction
- `in_pc` in `register_t`: PC of `in_instr`
- `wb_en` in 1: writeback strobe
- `wb_rd` in 5: writeback destination
- `wb_data` in `register_t`: writeback value
- `alu_enable` out 1: one-cycle issue pulse to ALU
- `alu_instr` out `instruction_t`: issued instruction
- `alu_op1`, `alu_op2`, `alu_pc` out `register_t`: ALU operands and PC
- `alu_rd` out 5: destination tag carried alongside to writeback
- `illegal` out 1: one-cycle pulse, accepted instruction not ALU class

## Operation
- Accept on `in_valid && in_ready`; classify with the `M_*` casez patterns from `opcodes`.
- R-type: op1=R[rs1], op2=R[rs2]. I-type arith/logic/compare: op2=sign-extended instr[31:20]. SLLI/SRLI/SRAI: op2={27'b0, instr[24:20]}. LUI/AUIPC: op1={instr[31:12],12'b0}, op2=0, `alu_pc`=in_pc.
- Reads of x0 return 0; writes with `wb_rd`=0 ignored; rd=0 never marked pending.
- Scoreboard: bit set at issue for rd≠0; cleared on `wb_en` for `wb_rd`. Same-cycle set and clear of the same register: set wins.
- Hazard: stall (`in_ready`=0) if any used source (rs1, rs2 when R-type) or rd is pending and not cleared this cycle by the write port (bypass case, see Configuration).
- Non-ALU instruction: consumed (`in_ready`=1), no `alu_enable`, `illegal` pulses next cycle, scoreboard unchanged.
- Write port updates the register file at the clock edge regardless of stalls.

## Timing
- Reset: all `alu_*` outputs 0, `alu_enable`=0, `illegal`=0, register file and scoreboard cleared; `in_ready`=1 once reset deasserts.
- Accept at edge N → `alu_enable`=1 and operands valid for cycle N+1; ALU result registered at edge N+2.
- `alu_enable` is high for exactly one cycle per accepted ALU instruction; back-to-back independent instructions issue every cycle.
- `in_ready` is combinational from `in_instr`, scoreboard and write port; upstream must hold `in_instr` stable while `in_valid` and not ready.
- Reset asserted mid-stall: pending state discarded; the stalled instruction is not issued.

## Configuration
- `OPFETCH_BYPASS_EN` defined: a source/rd pending but written by `wb_en` this cycle does not stall; operand taken from `wb_data`. Dependent instruction issues the same cycle as writeback.
- Undefined: stall until the pending bit has actually cleared; operand read from the register file one cycle after writeback (one extra stall cycle per dependency).

## Structure
- `opcodes` package gains `reg_idx_t` (5-bit), `imm_i`/`imm_u`/`shamt` extraction functions and an `is_alu_op` classifier shared with the ALU.
- Sub-module `op_regfile`: 2 async read ports, 1 write port, x0 forced to zero, async active-low reset.
- Scoreboard, classification and issue register live in `operand_fetch`.

## Test plan
- Reset, then issue ADDI x1,x0,5 → next cycle `alu_enable`=1, op1=0, op2=5, `alu_rd`=1.
- ADDI x2,x0,-1 → op2=32'hFFFF_FFFF; SRAI x3,x2,4 → op2=4 (no sign extension into shamt).
- LUI x4,0x12345 then AUIPC at pc=0x100 → op1=32'h1234_5000 both; `alu_pc`=0x100.
- ADD x5,x1,x1 right after ADDI x1 with wb 2 cycles later → `in_ready` low until wb; bypass on: issues in the wb cycle with op1=op2=wb_data; off: one cycle later.
- Issue to x6 twice back-to-back → second stalls (WAW) until first retires; same-cycle set/clear leaves x6 pending.
- Feed LW instruction → consumed, `illegal` pulse, no `alu_enable`; assert reset during a stall → outputs 0, no issue after release.
